// File: rtl/io_port_pkg.sv
// Shared types and constants for the IO port controller: input-handshake states,
// seven-segment encodings and the binary-to-BCD iteration count.
package io_port_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StGrant,
    StWaitRel
  } in_state_e;

  localparam logic [6:0]  SEG_BLANK  = 7'h7F;
  localparam logic [6:0]  SEG_MINUS  = 7'b0111111;
  localparam int unsigned BCD_ITER   = 32;
  localparam int unsigned NUM_DIGITS = 7;

  // Active-low {g,f,e,d,c,b,a}; codes above 9 never occur and show blank.
  function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// One BCD digit to active-low seven-segment pattern, with forced blanking.
module seg7_decoder
  import io_port_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  assign seg_o = blank_i ? SEG_BLANK : digit_to_seg(digit_i);

endmodule

// File: rtl/io_port_ctrl.sv
// Processor IO port: debounced pushbutton handshake for IN instructions and a
// serial shift-add-3 binary-to-BCD converter driving eight seven-segment displays.
module io_port_ctrl
  import io_port_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 1000
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        input_flag,
  input  logic        output_flag,
  input  logic [31:0] out_data,
  input  logic        halt,
  input  logic [17:0] SW,
  input  logic        insert,
  output logic        stall,
  output logic [31:0] user_input,
  output logic        busy,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [6:0]  HEX6,
  output logic [6:0]  HEX7
);

  localparam int unsigned CntW    = $clog2(DEB_CYCLES + 1);
  localparam logic [CntW-1:0] DebMax  = CntW'(DEB_CYCLES);
  localparam logic [CntW-1:0] DebLast = CntW'(DEB_CYCLES - 1);
  localparam int unsigned IterW   = $clog2(BCD_ITER);
  localparam logic [IterW-1:0] IterLast = IterW'(BCD_ITER - 1);

  // ---------------------------------------------------------------------------
  // Input handshake
  // ---------------------------------------------------------------------------
  in_state_e       state_q;
  logic [CntW-1:0] deb_cnt_q;
  logic [31:0]     user_input_q;
  logic            target_lvl;

  // ARMED waits for a press (0), WAIT_REL for a release (1).
  assign target_lvl = (state_q == StWaitRel);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      deb_cnt_q    <= '0;
      user_input_q <= '0;
    end else if (halt) begin
      state_q   <= StIdle;
      deb_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          deb_cnt_q <= '0;
          if (input_flag) state_q <= StArmed;
        end
        StArmed, StWaitRel: begin
          if (insert != target_lvl) begin
            deb_cnt_q <= '0;
          end else if (deb_cnt_q >= DebLast) begin
            deb_cnt_q <= DebMax;
            if (state_q == StArmed) begin
              user_input_q <= {14'b0, SW};
              state_q      <= StGrant;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            deb_cnt_q <= deb_cnt_q + CntW'(1);
          end
        end
        StGrant: begin
          deb_cnt_q <= '0;
          state_q   <= StWaitRel;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign stall      = reset & input_flag & ~halt & (state_q != StGrant);
  assign user_input = user_input_q;

  // ---------------------------------------------------------------------------
  // Output conversion
  // ---------------------------------------------------------------------------
  logic [31:0]           bin_q, bin_d;
  logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
  logic                  neg_q;
  logic                  busy_q;
  logic [IterW-1:0]      iter_q;
  logic [7:0][6:0]       hex_q;
  logic [NUM_DIGITS-1:0] blank;
  logic [NUM_DIGITS-1:0][6:0] seg_next;

  // Only the low digits are kept: they never depend on the discarded higher ones.
  always_comb begin
    logic [4*NUM_DIGITS-1:0] adj;
    adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    bcd_d = {adj[4*NUM_DIGITS-2:0], bin_q[31]};
    bin_d = {bin_q[30:0], 1'b0};
  end

  // Leading-zero blanking; the ones digit always shows.
  always_comb begin
    blank = '0;
    blank[NUM_DIGITS-1] = (bcd_d[4*NUM_DIGITS-1 -: 4] == 4'd0);
    for (int k = NUM_DIGITS - 2; k >= 1; k--) begin
      blank[k] = blank[k+1] && (bcd_d[4*k +: 4] == 4'd0);
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : gen_dec
    seg7_decoder u_dec (
      .digit_i(bcd_d[4*g +: 4]),
      .blank_i(blank[g]),
      .seg_o  (seg_next[g])
    );
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      neg_q  <= 1'b0;
      busy_q <= 1'b0;
      iter_q <= '0;
      hex_q  <= {8{SEG_BLANK}};
    end else if (output_flag) begin
      bin_q  <= out_data[31] ? (~out_data + 32'd1) : out_data;
      bcd_q  <= '0;
      neg_q  <= out_data[31];
      busy_q <= 1'b1;
      iter_q <= '0;
    end else if (busy_q) begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      iter_q <= iter_q + IterW'(1);
      if (iter_q == IterLast) begin
        busy_q <= 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) hex_q[i] <= seg_next[i];
        hex_q[7] <= neg_q ? SEG_MINUS : SEG_BLANK;
      end
    end
  end

  assign busy = busy_q;
  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];
  assign HEX6 = hex_q[6];
  assign HEX7 = hex_q[7];

endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed bench for io_port_ctrl with a short debounce window.
module tb_io_port_ctrl;

  localparam int unsigned DEB = 4;

  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
  localparam logic [6:0] S5 = 7'h12, S6 = 7'h02, S7 = 7'h78, S8 = 7'h00, S9 = 7'h10;
  localparam logic [6:0] BL = 7'h7F, MI = 7'h3F;

  logic        CLK = 1'b0;
  logic        reset, input_flag, output_flag, halt, insert;
  logic [31:0] out_data;
  logic [17:0] SW;
  logic        stall, busy;
  logic [31:0] user_input;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
  logic [55:0] hex_all;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  io_port_ctrl #(.DEB_CYCLES(DEB)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .input_flag (input_flag),
    .output_flag(output_flag),
    .out_data   (out_data),
    .halt       (halt),
    .SW         (SW),
    .insert     (insert),
    .stall      (stall),
    .user_input (user_input),
    .busy       (busy),
    .HEX0       (HEX0),
    .HEX1       (HEX1),
    .HEX2       (HEX2),
    .HEX3       (HEX3),
    .HEX4       (HEX4),
    .HEX5       (HEX5),
    .HEX6       (HEX6),
    .HEX7       (HEX7)
  );

  assign hex_all = {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

  typedef struct {
    logic [31:0] val;
    logic [55:0] hex;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge CLK);
  endtask

  task automatic convert(input int idx, input logic [31:0] val, input logic [55:0] prev,
                         input logic [55:0] exp);
    int cnt;
    out_data    = val;
    output_flag = 1'b1;
    step();
    output_flag = 1'b0;
    check($sformatf("conv%0d hold", idx), 64'(hex_all), 64'(prev));
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      step();
    end
    check($sformatf("conv%0d busy cycles", idx), 64'(cnt), 64'(32));
    check($sformatf("conv%0d display", idx), 64'(hex_all), 64'(exp));
  endtask

  initial begin
    logic [55:0] prev;
    int bc, guard;

    vecs[0] = '{32'd1234,       {BL, BL, BL, BL, S1, S2, S3, S4}};
    vecs[1] = '{32'hFFFFFFF9,   {MI, BL, BL, BL, BL, BL, BL, S7}};
    vecs[2] = '{32'h80000000,   {MI, S7, S4, S8, S3, S6, S4, S8}};
    vecs[3] = '{32'd10000000,   {BL, BL, BL, BL, BL, BL, BL, S0}};
    vecs[4] = '{32'd1000,       {BL, BL, BL, BL, S1, S0, S0, S0}};
    vecs[5] = '{32'h7FFFFFFF,   {BL, S7, S4, S8, S3, S6, S4, S7}};
    vecs[6] = '{32'd0,          {BL, BL, BL, BL, BL, BL, BL, S0}};

    reset = 1'b0; input_flag = 1'b1; output_flag = 1'b0; halt = 1'b0;
    insert = 1'b1; out_data = '0; SW = '0;
    step(2);
    check("reset stall", 64'(stall), 64'(0));
    check("reset busy", 64'(busy), 64'(0));
    check("reset user_input", 64'(user_input), 64'(0));
    check("reset hex", 64'(hex_all), 64'({8{BL}}));
    input_flag = 1'b0;
    reset = 1'b1;
    step();

    // Basic capture
    input_flag = 1'b1; SW = 18'h2A5A5;
    step();
    check("armed stall", 64'(stall), 64'(1));
    insert = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("press debouncing stall", 64'(stall), 64'(1));
    end
    check("press no early capture", 64'(user_input), 64'(0));
    step();
    check("grant stall", 64'(stall), 64'(0));
    check("grant capture", 64'(user_input), 64'(32'h0002A5A5));
    step();
    check("wait_rel stall", 64'(stall), 64'(1));
    SW = 18'h00001;
    step(3);
    check("no capture before release", 64'(user_input), 64'(32'h0002A5A5));
    insert = 1'b1;
    step(4);
    insert = 1'b0;
    step();
    step(3);
    check("rearm stall", 64'(stall), 64'(1));
    check("rearm no early capture", 64'(user_input), 64'(32'h0002A5A5));
    step();
    check("second grant stall", 64'(stall), 64'(0));
    check("second capture", 64'(user_input), 64'(32'h00000001));
    step();
    insert = 1'b1;
    step(4);
    input_flag = 1'b0;
    step();
    check("idle stall", 64'(stall), 64'(0));

    // Bouncing press never completes a window
    input_flag = 1'b1; SW = 18'h3FFFF;
    step();
    for (int i = 0; i < 8; i++) begin
      insert = (i % 2 == 1);
      step();
      check($sformatf("bounce%0d stall", i), 64'(stall), 64'(1));
    end
    check("bounce no capture", 64'(user_input), 64'(32'h00000001));
    insert = 1'b0;
    step(3);
    check("post-bounce stall", 64'(stall), 64'(1));
    step();
    check("post-bounce grant", 64'(stall), 64'(0));
    check("post-bounce capture", 64'(user_input), 64'(32'h0003FFFF));
    step();

    // Halt forces IDLE from WAIT_REL
    halt = 1'b1; SW = 18'h12345;
    #1;
    check("halt stall", 64'(stall), 64'(0));
    step();
    check("halt keeps user_input", 64'(user_input), 64'(32'h0003FFFF));
    halt = 1'b0;
    step();
    step(3);
    check("after halt no early capture", 64'(user_input), 64'(32'h0003FFFF));
    step();
    check("after halt grant", 64'(stall), 64'(0));
    check("after halt capture", 64'(user_input), 64'(32'h00012345));
    step();
    insert = 1'b1;
    step(4);
    input_flag = 1'b0;
    step();

    // Conversion table
    prev = {8{BL}};
    for (int i = 0; i < 7; i++) begin
      convert(i, vecs[i].val, prev, vecs[i].hex);
      prev = vecs[i].hex;
    end

    // Restart mid-conversion
    bc = 0;
    out_data = 32'd5; output_flag = 1'b1;
    step();
    output_flag = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (busy) bc++;
      step();
    end
    out_data = 32'd9; output_flag = 1'b1;
    if (busy) bc++;
    step();
    output_flag = 1'b0;
    check("restart hold", 64'(hex_all), 64'(prev));
    guard = 0;
    while (busy && guard < 100) begin
      bc++; guard++;
      step();
    end
    check("restart busy cycles", 64'(bc), 64'(42));
    check("restart display", 64'(hex_all), 64'({BL, BL, BL, BL, BL, BL, BL, S9}));

    // Reset during conversion and while ARMED
    input_flag = 1'b1; insert = 1'b1; SW = 18'h00ABC;
    step();
    out_data = 32'd1234; output_flag = 1'b1;
    step();
    output_flag = 1'b0;
    step(5);
    #2 reset = 1'b0;
    #1;
    check("async reset hex", 64'(hex_all), 64'({8{BL}}));
    check("async reset busy", 64'(busy), 64'(0));
    check("async reset stall", 64'(stall), 64'(0));
    check("async reset user_input", 64'(user_input), 64'(0));
    step();
    reset = 1'b1;
    step();
    insert = 1'b0;
    step(3);
    check("post-reset busy", 64'(busy), 64'(0));
    check("post-reset stall", 64'(stall), 64'(1));
    step();
    check("post-reset grant", 64'(stall), 64'(0));
    check("post-reset capture", 64'(user_input), 64'(32'h00000ABC));
    check("post-reset hex", 64'(hex_all), 64'({8{BL}}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/io_port_ctrl.md
IO_PORT_CTRL -- requirements
Module: io_port_ctrl

Interface
REQ-001 Parameter: DEB_CYCLES, 1000, consecutive cycles insert must hold a level to count as debounced.
REQ-002 Port: CLK  in  1  system clock; all state on rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-low reset.
REQ-004 Port: input_flag  in  1  IN instruction in execution (control unit).
REQ-005 Port: output_flag  in  1  OUT instruction; one-cycle pulse per instruction.
REQ-006 Port: out_data  in  32  value to display (register read data 1).
REQ-007 Port: halt  in  1  processor halted.
REQ-008 Port: SW  in  18  user switches.
REQ-009 Port: insert  in  1  raw pushbutton, active-low (pressed = 0).
REQ-010 Port: stall  out  1  holds PC and blocks register write while high.
REQ-011 Port: user_input  out  32  captured switch value for write-back.
REQ-012 Port: busy  out  1  BCD conversion in progress.
REQ-013 Port: HEX0..HEX7  out  7 each  active-low segments {g,f,e,d,c,b,a}.

Function
REQ-014 Input FSM states: IDLE, ARMED, GRANT, WAIT_REL.
REQ-015 IDLE: input_flag=1 and halt=0 -> ARMED.
REQ-016 ARMED: insert debounced low (DEB_CYCLES consecutive 0 samples) -> latch user_input={14'b0,SW}, -> GRANT.
REQ-017 GRANT: exactly one cycle, then -> WAIT_REL unconditionally.
REQ-018 WAIT_REL: insert debounced high (DEB_CYCLES consecutive 1 samples) -> IDLE; no new capture before release.
REQ-019 stall = input_flag AND NOT halt AND state!=GRANT (combinational); zero added latency.
REQ-020 Debounce counter restarts on any sample differing from target level; saturates at DEB_CYCLES.
REQ-021 halt=1 in any input state -> IDLE next cycle; user_input retained.
REQ-022 Output path: output_flag=1 latches out_data, starts 32-iteration shift-add-3 binary-to-BCD, one iteration per cycle, busy=1.
REQ-023 Sign: out_data[31]=1 -> magnitude = two's-complement negation, HEX7 shows minus (7'b0111111); else HEX7 blank.
REQ-024 Magnitude 0x80000000 converts as 2147483648.
REQ-025 HEX6..HEX0 show the low 7 BCD digits; higher digits discarded.
REQ-026 Leading-zero blanking on HEX6..HEX1; HEX0 always shows a digit (0 for zero).
REQ-027 HEX0..HEX7 update atomically on the cycle after the final iteration (latency 33 cycles from output_flag); busy falls the same cycle.
REQ-028 output_flag during busy aborts and restarts with the new value; displays keep the prior value until completion.
REQ-029 Input and output paths are independent; simultaneous input_flag and output_flag are both serviced.
REQ-030 halt does not affect a conversion in progress.

Reset
REQ-031 reset=0 asynchronously: input FSM IDLE, debounce counters 0, user_input=0, busy=0, conversion cleared, HEX0..HEX7=7'h7F (blank).
REQ-032 stall=0 while reset asserted; conversion abandoned if reset occurs mid-conversion.
REQ-033 First edge after reset release: normal operation; a pending input_flag enters ARMED.

Structure
REQ-034 Package io_port_pkg holds input-state enum, SEG_BLANK=7'h7F, SEG_MINUS=7'b0111111, BCD_ITER=32, digit-to-segment table.
REQ-035 One sub-module seg7_decoder (4-bit digit + blank -> 7-bit active-low), instantiated 7 times.

Verification (DEB_CYCLES=4)
REQ-036 input_flag=1, SW=18'h2A5A5, insert low 4 cycles -> stall high until GRANT cycle, user_input=32'h0002A5A5, stall low exactly 1 cycle.
REQ-037 insert bouncing 0,1,0,1 for 8 cycles while ARMED -> no capture, stall stays 1.
REQ-038 output_flag, out_data=32'd1234 -> busy 32 cycles, cycle 33 HEX3..HEX0="1234", HEX7..HEX4 blank.
REQ-039 output_flag, out_data=32'hFFFFFFF9 -> HEX7 minus, HEX0="7", others blank; 32'h80000000 -> minus, "7483648".
REQ-040 output_flag with 5, second output_flag with 9 at iteration 10 -> final display "9" only, busy total 42 cycles.
REQ-041 reset=0 mid-conversion and in ARMED -> HEX all 7'h7F, busy=0, stall=0 immediately, user_input=0.
